// File: rtl/rr_mux_arbiter_4_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter.
// No logic, only types and constants.
// No flow control of its own.
package rr_mux_arbiter_4_pkg;

    // Number of requester lanes sharing the mux
    localparam int N_REQ = 4;

    // Arbiter FSM encoding
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_mux_arbiter_4_pick.sv
// First set request at or after a start index, wrapping modulo 4.
// Purely combinational, zero latency.
// No backpressure; found=0 means no request is set.
module rr_pick_4 (
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Walk start, start+1, start+2, start+3 and keep the first hit
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int k = 0; k < 4; k++) begin
            cand = start + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter owning a shared 4:1 data mux, bursts capped at MAX_HOLD.
// Latency: grant one clock after request; y follows sel combinationally.
// No backpressure: requesters hold req until served, consumers qualify y with y_valid.
module rr_mux_arbiter_4
    import rr_mux_arbiter_4_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   in_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [1:0]               sel,
    output logic [WIDTH-1:0]         y,
    output logic                     y_valid
);

    localparam int              HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(MAX_HOLD - 1);

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n;
    logic [HCW-1:0]   hold_cnt, hold_n;
    logic [N_REQ-1:0] gnt_n;
    logic [1:0]       sel_n;

    logic [1:0]       pick_start;
    logic             pick_found;
    logic [1:0]       pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic             rel_now;

    // While busy the search always begins just past the owner, so a
    // released owner is considered last; when idle it begins at ptr.
    assign pick_start  = (state == BUSY) ? sel + 2'd1 : ptr;
    assign pick_onehot = N_REQ'(1) << pick_idx;
    assign rel_now     = !req[sel] || (hold_cnt == HOLD_LAST);

    rr_pick_4 u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State register, including the registered grant and mux select
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            hold_cnt <= '0;
            gnt      <= '0;
            sel      <= 2'd0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_n;
            sel      <= sel_n;
        end
    end

    // Next-state: grant from idle, keep, or hand over without a bubble
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        gnt_n   = gnt;
        sel_n   = sel;
        case (state)
            IDLE: begin
                hold_n = '0;
                if (pick_found) begin
                    state_n = BUSY;
                    gnt_n   = pick_onehot;
                    sel_n   = pick_idx;
                end else begin
                    gnt_n   = '0;
                    sel_n   = 2'd0;
                end
            end
            BUSY: begin
                if (rel_now) begin
                    ptr_n  = sel + 2'd1;
                    hold_n = '0;
                    if (pick_found) begin
                        gnt_n = pick_onehot;
                        sel_n = pick_idx;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        sel_n   = 2'd0;
                    end
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                sel_n   = 2'd0;
                hold_n  = '0;
            end
        endcase
    end

    // Outputs: shared mux driven by the registered select
    always_comb begin
        y       = in_data[sel*WIDTH +: WIDTH];
        y_valid = |gnt;
    end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Bench for rr_mux_arbiter_4 with WIDTH=8, MAX_HOLD=4.
// Table of per-cycle vectors plus a continuous-contention sequence.
// Expected values are queued at drive time and popped after the edge.
module tb_rr_mux_arbiter_4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] in_data = 32'h0;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [7:0]  y;
    logic        y_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter_4 #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .in_data (in_data),
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [1:0]  sel;
        logic [7:0]  y;
        logic        valid;
    } vec_t;

    typedef struct {
        string       name;
        logic [3:0]  gnt;
        logic [1:0]  sel;
        logic [7:0]  y;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[27];

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [31:0] d,
                                input logic [3:0] g, input logic [1:0] s,
                                input logic [7:0] yy, input logic v);
        vec_t t;
        t.rst = r; t.req = rq; t.data = d;
        t.gnt = g; t.sel = s; t.y = yy; t.valid = v;
        return t;
    endfunction

    task automatic cmp(input string nm, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s %s actual=%0h required=%0h", nm, field, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, check after the edge
    task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] d,
                        input exp_t e);
        exp_t got;
        @(negedge clk);
        rst     = r;
        req     = rq;
        in_data = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard_empty actual=0 required=1", e.name);
        end else begin
            got = sb.pop_front();
            cmp(got.name, "gnt", 32'(gnt), 32'(got.gnt));
            cmp(got.name, "sel", 32'(sel), 32'(got.sel));
            cmp(got.name, "y", 32'(y), 32'(got.y));
            cmp(got.name, "y_valid", 32'(y_valid), 32'(got.valid));
        end
    endtask

    localparam logic [31:0] D0 = 32'h44332211;
    localparam logic [31:0] D2 = 32'h00A50000;

    initial begin
        exp_t        e;
        logic [31:0] d;
        int          owner;

        // Reset, then release with all requesting
        vecs[0]  = mk(1'b1, 4'hF, D0, 4'h0, 2'd0, 8'h11, 1'b0);
        vecs[1]  = mk(1'b1, 4'hF, D0, 4'h0, 2'd0, 8'h11, 1'b0);
        vecs[2]  = mk(1'b0, 4'hF, D0, 4'h1, 2'd0, 8'h11, 1'b1);
        vecs[3]  = mk(1'b1, 4'h0, D0, 4'h0, 2'd0, 8'h11, 1'b0);
        // Single requester lane2, then drop
        vecs[4]  = mk(1'b0, 4'h4, D2, 4'h4, 2'd2, 8'hA5, 1'b1);
        vecs[5]  = mk(1'b0, 4'h0, D2, 4'h0, 2'd0, 8'h00, 1'b0);
        // Burst limit with req=0011 (ptr is 3 here, so lane0 wins first)
        vecs[6]  = mk(1'b0, 4'h3, D0, 4'h1, 2'd0, 8'h11, 1'b1);
        vecs[7]  = mk(1'b0, 4'h3, D0, 4'h1, 2'd0, 8'h11, 1'b1);
        vecs[8]  = mk(1'b0, 4'h3, D0, 4'h1, 2'd0, 8'h11, 1'b1);
        vecs[9]  = mk(1'b0, 4'h3, D0, 4'h1, 2'd0, 8'h11, 1'b1);
        vecs[10] = mk(1'b0, 4'h3, D0, 4'h2, 2'd1, 8'h22, 1'b1);
        vecs[11] = mk(1'b0, 4'h3, D0, 4'h2, 2'd1, 8'h22, 1'b1);
        vecs[12] = mk(1'b0, 4'h3, D0, 4'h2, 2'd1, 8'h22, 1'b1);
        vecs[13] = mk(1'b0, 4'h3, D0, 4'h2, 2'd1, 8'h22, 1'b1);
        vecs[14] = mk(1'b0, 4'h3, D0, 4'h1, 2'd0, 8'h11, 1'b1);
        // Early release without bubble: lane1 owns, drops, lane3 follows
        vecs[15] = mk(1'b0, 4'hA, D0, 4'h2, 2'd1, 8'h22, 1'b1);
        vecs[16] = mk(1'b0, 4'hA, D0, 4'h2, 2'd1, 8'h22, 1'b1);
        vecs[17] = mk(1'b0, 4'h8, D0, 4'h8, 2'd3, 8'h44, 1'b1);
        // Wrap-around: lane3 at limit with req=1001 hands to lane0
        vecs[18] = mk(1'b0, 4'h9, D0, 4'h8, 2'd3, 8'h44, 1'b1);
        vecs[19] = mk(1'b0, 4'h9, D0, 4'h8, 2'd3, 8'h44, 1'b1);
        vecs[20] = mk(1'b0, 4'h9, D0, 4'h8, 2'd3, 8'h44, 1'b1);
        vecs[21] = mk(1'b0, 4'h9, D0, 4'h1, 2'd0, 8'h11, 1'b1);
        // Reset mid-burst: lane2 at hold_cnt=2, then req=0110 gives lane1
        vecs[22] = mk(1'b0, 4'h4, D0, 4'h4, 2'd2, 8'h33, 1'b1);
        vecs[23] = mk(1'b0, 4'h4, D0, 4'h4, 2'd2, 8'h33, 1'b1);
        vecs[24] = mk(1'b0, 4'h4, D0, 4'h4, 2'd2, 8'h33, 1'b1);
        vecs[25] = mk(1'b1, 4'h6, D0, 4'h0, 2'd0, 8'h11, 1'b0);
        vecs[26] = mk(1'b0, 4'h6, D0, 4'h2, 2'd1, 8'h22, 1'b1);

        for (int i = 0; i < 27; i++) begin
            e.name  = $sformatf("vec%0d", i);
            e.gnt   = vecs[i].gnt;
            e.sel   = vecs[i].sel;
            e.y     = vecs[i].y;
            e.valid = vecs[i].valid;
            step(vecs[i].rst, vecs[i].req, vecs[i].data, e);
        end

        // Full contention from reset: each lane holds for 4 cycles in turn,
        // grant never drops, y tracks the owner's lane with changing data.
        e.name = "contend_rst"; e.gnt = 4'h0; e.sel = 2'd0; e.y = 8'h11; e.valid = 1'b0;
        step(1'b1, 4'hF, D0, e);
        for (int k = 0; k < 20; k++) begin
            d       = $urandom;
            owner   = (k / 4) % 4;
            e.name  = $sformatf("contend%0d", k);
            e.gnt   = 4'(1 << owner);
            e.sel   = 2'(owner);
            e.y     = d[owner*8 +: 8];
            e.valid = 1'b1;
            step(1'b0, 4'hF, d, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
